// File: rtl/layer_compositor.sv
// Resolves per-layer edge/fill hits into one palette index through a registered
// priority tree; layer configuration is double-buffered and swapped at frame end.
module layer_compositor #(
    parameter int PIXEL_WIDTH = 1280,
    parameter int PIXEL_HEIGHT = 720,
    parameter int NUM_LAYERS = 8,
    parameter int COLOR_BITS = 4,
    parameter logic [COLOR_BITS-1:0] BACKGROUND_COLOR = COLOR_BITS'(1),
    parameter logic [COLOR_BITS-1:0] EDGE_COLOR = COLOR_BITS'(0),
    parameter int BLINK_SHIFT = 4
) (
    input  logic                              clk_in,
    input  logic                              rst_in,
    input  logic [$clog2(PIXEL_WIDTH)-1:0]    hcount_in,
    input  logic [$clog2(PIXEL_HEIGHT)-1:0]   vcount_in,
    input  logic                              pixel_valid_in,
    input  logic [NUM_LAYERS-1:0]             edge_in,
    input  logic [NUM_LAYERS-1:0]             fill_in,
    input  logic                              cfg_we_in,
    input  logic [$clog2(NUM_LAYERS+1)-1:0]   cfg_layer_in,
    input  logic [COLOR_BITS-1:0]             cfg_color_in,
    input  logic                              cfg_enable_in,
    input  logic                              cfg_blink_in,
    input  logic                              commit_in,
    output logic                              commit_pending_out,
    output logic [COLOR_BITS-1:0]             color_idx_out,
    output logic                              pixel_valid_out,
    output logic [$clog2(PIXEL_WIDTH)-1:0]    hcount_out,
    output logic [$clog2(PIXEL_HEIGHT)-1:0]   vcount_out,
    output logic [15:0]                       frame_count_out
);
    localparam int HW = $clog2(PIXEL_WIDTH);
    localparam int VW = $clog2(PIXEL_HEIGHT);
    localparam int LW = $clog2(NUM_LAYERS + 1);
    localparam int LEVELS = $clog2(NUM_LAYERS);

    function automatic int node_count(input int level);
        return (NUM_LAYERS + (1 << level) - 1) >> level;
    endfunction

    typedef enum logic {IDLE, PENDING} commit_state_t;
    commit_state_t state, state_next;

    logic [COLOR_BITS-1:0] shadow_color [NUM_LAYERS];
    logic [COLOR_BITS-1:0] active_color [NUM_LAYERS];
    logic [NUM_LAYERS-1:0] shadow_enable, shadow_blink;
    logic [NUM_LAYERS-1:0] active_enable, active_blink;
    logic [15:0]           frame_count;
    logic                  frame_end, apply_commit;

    assign frame_end = pixel_valid_in && (hcount_in == HW'(PIXEL_WIDTH - 1))
                       && (vcount_in == VW'(PIXEL_HEIGHT - 1));

    always_ff @(posedge clk_in) begin
        if (rst_in) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (commit_in && !frame_end) state_next = PENDING;
            PENDING: if (frame_end) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        commit_pending_out = (state == PENDING);
        apply_commit       = frame_end && ((state == PENDING) || commit_in);
    end

    // Non-blocking copy means a write in the commit cycle stays in the shadow only.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int unsigned i = 0; i < NUM_LAYERS; i++) begin
                shadow_color[i] <= BACKGROUND_COLOR;
                active_color[i] <= BACKGROUND_COLOR;
            end
            shadow_enable <= '0;
            shadow_blink  <= '0;
            active_enable <= '0;
            active_blink  <= '0;
            frame_count   <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_LAYERS; i++) begin
                if (cfg_we_in && (cfg_layer_in == LW'(i))) begin
                    shadow_color[i]  <= cfg_color_in;
                    shadow_enable[i] <= cfg_enable_in;
                    shadow_blink[i]  <= cfg_blink_in;
                end
            end
            if (apply_commit) begin
                active_color  <= shadow_color;
                active_enable <= shadow_enable;
                active_blink  <= shadow_blink;
            end
            if (frame_end) frame_count <= frame_count + 16'd1;
        end
    end

    logic                  s0_hit [NUM_LAYERS];
    logic [COLOR_BITS-1:0] s0_col [NUM_LAYERS];

    always_comb begin
        for (int unsigned i = 0; i < NUM_LAYERS; i++) begin
            s0_hit[i] = active_enable[i] && !(active_blink[i] && frame_count[BLINK_SHIFT])
                        && (edge_in[i] || fill_in[i]);
            s0_col[i] = edge_in[i] ? EDGE_COLOR : active_color[i];
        end
    end

    // Level 0 registers the per-layer results; each further level halves the node count.
    for (genvar k = 0; k <= LEVELS; k++) begin : lvl
        localparam int CNT = node_count(k);
        logic                  hit   [CNT];
        logic [COLOR_BITS-1:0] col   [CNT];
        logic                  hit_d [CNT];
        logic [COLOR_BITS-1:0] col_d [CNT];
        logic                  valid, valid_d;
        logic [HW-1:0]         hcount, hcount_d;
        logic [VW-1:0]         vcount, vcount_d;

        if (k == 0) begin : g_leaf
            assign hit_d    = s0_hit;
            assign col_d    = s0_col;
            assign valid_d  = pixel_valid_in;
            assign hcount_d = hcount_in;
            assign vcount_d = vcount_in;
        end else begin : g_merge
            for (genvar j = 0; j < CNT; j++) begin : node
                if (2 * j + 1 < node_count(k - 1)) begin : g_pair
                    assign hit_d[j] = lvl[k-1].hit[2*j] || lvl[k-1].hit[2*j+1];
                    assign col_d[j] = lvl[k-1].hit[2*j] ? lvl[k-1].col[2*j] : lvl[k-1].col[2*j+1];
                end else begin : g_pass
                    assign hit_d[j] = lvl[k-1].hit[2*j];
                    assign col_d[j] = lvl[k-1].col[2*j];
                end
            end
            assign valid_d  = lvl[k-1].valid;
            assign hcount_d = lvl[k-1].hcount;
            assign vcount_d = lvl[k-1].vcount;
        end

        always_ff @(posedge clk_in) begin
            if (rst_in) begin
                for (int unsigned j = 0; j < CNT; j++) begin
                    hit[j] <= 1'b0;
                    col[j] <= '0;
                end
                valid  <= 1'b0;
                hcount <= '0;
                vcount <= '0;
            end else begin
                hit    <= hit_d;
                col    <= col_d;
                valid  <= valid_d;
                hcount <= hcount_d;
                vcount <= vcount_d;
            end
        end
    end

    assign pixel_valid_out = lvl[LEVELS].valid;
    assign hcount_out      = lvl[LEVELS].hcount;
    assign vcount_out      = lvl[LEVELS].vcount;
    assign color_idx_out   = (lvl[LEVELS].valid && lvl[LEVELS].hit[0]) ? lvl[LEVELS].col[0]
                                                                        : BACKGROUND_COLOR;
    assign frame_count_out = frame_count;
endmodule

// File: tb/tb_layer_compositor.sv
// Directed bench for layer_compositor (8 layers, blink on frame_count bit 0, latency 4).
module tb_layer_compositor;
    localparam int L = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, pv, we, cen, cbl, commit;
    logic [10:0] hc;
    logic [9:0]  vc;
    logic [7:0]  edg, fil;
    logic [3:0]  cl, cc;
    logic        pend, pvo;
    logic [3:0]  color;
    logic [10:0] hco;
    logic [9:0]  vco;
    logic [15:0] fc;

    layer_compositor #(
        .PIXEL_WIDTH(1280), .PIXEL_HEIGHT(720), .NUM_LAYERS(8), .COLOR_BITS(4),
        .BACKGROUND_COLOR(4'h1), .EDGE_COLOR(4'h0), .BLINK_SHIFT(0)
    ) dut (
        .clk_in(clk), .rst_in(rst), .hcount_in(hc), .vcount_in(vc), .pixel_valid_in(pv),
        .edge_in(edg), .fill_in(fil), .cfg_we_in(we), .cfg_layer_in(cl), .cfg_color_in(cc),
        .cfg_enable_in(cen), .cfg_blink_in(cbl), .commit_in(commit),
        .commit_pending_out(pend), .color_idx_out(color), .pixel_valid_out(pvo),
        .hcount_out(hco), .vcount_out(vco), .frame_count_out(fc)
    );

    typedef struct { logic v; logic [10:0] h; logic [9:0] vv; logic [3:0] c; } exp_t;
    typedef struct { logic v; logic [7:0] e; logic [7:0] f; logic [3:0] c; } vec_t;

    exp_t        q[$];
    vec_t        vecs[11];
    int          errors = 0;
    int          checks = 0;
    logic [15:0] exp_fc = '0;
    logic [3:0]  m_col [8];
    logic [7:0]  m_en, m_bl;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    task automatic pix(input logic v, input logic [10:0] h, input logic [9:0] y,
                       input logic [7:0] e, input logic [7:0] f);
        pv = v; hc = h; vc = y; edg = e; fil = f;
    endtask

    task automatic idle();
        pv = 1'b0; edg = '0; fil = '0;
    endtask

    task automatic fe(input logic [7:0] e, input logic [7:0] f);
        pix(1'b1, 11'd1279, 10'd719, e, f);
    endtask

    task automatic cfg(input logic [3:0] layer, input logic [3:0] c, input logic en, input logic bl);
        we = 1'b1; cl = layer; cc = c; cen = en; cbl = bl;
    endtask

    // One clock: record what the current pixel must produce L cycles later, then compare.
    task automatic tick(input logic [3:0] expc);
        exp_t e;
        e.v = pv; e.h = hc; e.vv = vc; e.c = pv ? expc : 4'h1;
        q.push_back(e);
        if (pv && hc == 11'd1279 && vc == 10'd719) exp_fc++;
        @(posedge clk); #1;
        we = 1'b0; commit = 1'b0;
        if (q.size() == L) begin
            e = q.pop_front();
            check("color", {28'd0, color}, {28'd0, e.c});
            check("valid", {31'd0, pvo}, {31'd0, e.v});
            check("hv", {11'd0, hco, vco}, {11'd0, e.h, e.vv});
        end
        check("frame_count", {16'd0, fc}, {16'd0, exp_fc});
    endtask

    function automatic logic [3:0] model(input logic [7:0] e, input logic [7:0] f);
        for (int i = 0; i < 8; i++)
            if (m_en[i] && !(m_bl[i] && exp_fc[0]) && (e[i] || f[i])) return e[i] ? 4'h0 : m_col[i];
        return 4'h1;
    endfunction

    initial begin
        // L2 = colour 3, L5 = colour A, both enabled
        vecs[0]  = '{1'b1, 8'h00, 8'h24, 4'h3};
        vecs[1]  = '{1'b1, 8'h20, 8'h24, 4'h3};
        vecs[2]  = '{1'b1, 8'h04, 8'h24, 4'h0};
        vecs[3]  = '{1'b1, 8'h00, 8'h20, 4'hA};
        vecs[4]  = '{1'b1, 8'h00, 8'hDB, 4'h1};
        vecs[5]  = '{1'b1, 8'h20, 8'h00, 4'h0};
        vecs[6]  = '{1'b1, 8'h81, 8'h00, 4'h1};
        vecs[7]  = '{1'b1, 8'h00, 8'h04, 4'h3};
        vecs[8]  = '{1'b0, 8'h00, 8'hFF, 4'h1};
        vecs[9]  = '{1'b1, 8'h00, 8'hFF, 4'h3};
        vecs[10] = '{1'b1, 8'hFF, 8'h00, 4'h0};

        rst = 1'b1; pv = 1'b0; hc = '0; vc = '0; edg = '0; fil = '0;
        we = 1'b0; cl = '0; cc = '0; cen = 1'b0; cbl = 1'b0; commit = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_color", {28'd0, color}, 32'h1);
        check("rst_valid", {31'd0, pvo}, 32'h0);
        check("rst_fc", {16'd0, fc}, 32'h0);
        check("rst_pending", {31'd0, pend}, 32'h0);
        check("rst_hv", {11'd0, hco, vco}, 32'h0);
        rst = 1'b0;

        for (int i = 0; i < 6; i++) begin pix(1'b1, 11'(i), 10'd0, 8'h00, 8'hFF); tick(4'h1); end

        idle(); cfg(4'd2, 4'h3, 1'b1, 1'b0); tick(4'h1);
        cfg(4'd5, 4'hA, 1'b1, 1'b0); tick(4'h1);
        commit = 1'b1; tick(4'h1);
        check("pend_set", {31'd0, pend}, 32'h1);
        fe(8'h00, 8'h00); tick(4'h1);
        check("pend_clr", {31'd0, pend}, 32'h0);

        for (int i = 0; i < 11; i++) begin
            pix(vecs[i].v, 11'(i + 10), 10'd3, vecs[i].e, vecs[i].f);
            tick(vecs[i].c);
        end

        // Double buffer: shadow write mid-frame stays invisible until commit + frame end.
        idle(); cfg(4'd2, 4'h7, 1'b1, 1'b0); tick(4'h1);
        check("pend_after_write", {31'd0, pend}, 32'h0);
        pix(1'b1, 11'd100, 10'd4, 8'h00, 8'h04); tick(4'h3);
        commit = 1'b1; tick(4'h3);
        check("pend_commit", {31'd0, pend}, 32'h1);
        commit = 1'b1; tick(4'h3);
        check("pend_idem", {31'd0, pend}, 32'h1);
        tick(4'h3);
        fe(8'h00, 8'h04); tick(4'h3);
        check("pend_fe", {31'd0, pend}, 32'h0);
        pix(1'b1, 11'd0, 10'd0, 8'h00, 8'h04); tick(4'h7);

        // Commit, frame end and a write all in one cycle.
        idle(); cfg(4'd2, 4'h5, 1'b1, 1'b0); tick(4'h1);
        fe(8'h00, 8'h04); cfg(4'd2, 4'h9, 1'b1, 1'b0); commit = 1'b1; tick(4'h7);
        check("pend_same", {31'd0, pend}, 32'h0);
        pix(1'b1, 11'd1, 10'd0, 8'h00, 8'h04); tick(4'h5);
        idle(); commit = 1'b1; tick(4'h1);
        check("pend_again", {31'd0, pend}, 32'h1);
        fe(8'h00, 8'h04); tick(4'h5);
        pix(1'b1, 11'd2, 10'd0, 8'h00, 8'h04); tick(4'h9);

        // Out-of-range layer write must leave layer 0 disabled.
        idle(); cfg(4'd8, 4'hF, 1'b1, 1'b0); tick(4'h1);
        commit = 1'b1; tick(4'h1);
        fe(8'h00, 8'h00); tick(4'h1);
        pix(1'b1, 11'd3, 10'd0, 8'h00, 8'h05); tick(4'h9);

        // Blink on layer 1; frame_count is 5 here, 6 after the next frame end.
        idle(); cfg(4'd1, 4'h4, 1'b1, 1'b1); tick(4'h1);
        commit = 1'b1; tick(4'h1);
        fe(8'h00, 8'h00); tick(4'h1);
        pix(1'b1, 11'd4, 10'd0, 8'h00, 8'h02); tick(4'h4);
        fe(8'h00, 8'h02); tick(4'h4);
        pix(1'b1, 11'd5, 10'd0, 8'h00, 8'h02); tick(4'h1);
        pix(1'b1, 11'd6, 10'd0, 8'h00, 8'h06); tick(4'h9);
        fe(8'h00, 8'h02); tick(4'h1);
        pix(1'b1, 11'd7, 10'd0, 8'h00, 8'h02); tick(4'h4);

        // Random traffic against a linear-priority model of the current active config.
        for (int i = 0; i < 8; i++) m_col[i] = 4'h1;
        m_col[1] = 4'h4; m_col[2] = 4'h9; m_col[5] = 4'hA;
        m_en = 8'b0010_0110; m_bl = 8'b0000_0010;
        for (int i = 0; i < 200; i++) begin
            logic [7:0] e, f;
            e = 8'($urandom_range(0, 255)) & 8'($urandom_range(0, 255));
            f = 8'($urandom_range(0, 255));
            pix($urandom_range(0, 3) != 0, 11'($urandom_range(0, 1270)),
                10'($urandom_range(0, 719)), e, f);
            tick(model(e, f));
        end

        // Run frame_count up to FFFF and across the wrap.
        while (exp_fc != 16'hFFFF) begin fe(8'h00, 8'h00); tick(4'h1); end
        pix(1'b1, 11'd8, 10'd0, 8'h00, 8'h02); tick(4'h1);
        fe(8'h00, 8'h02); tick(4'h1);
        check("fc_wrap", {16'd0, fc}, 32'h0);
        pix(1'b1, 11'd9, 10'd0, 8'h00, 8'h02); tick(4'h4);

        // Reset with a commit pending and pixels in flight.
        idle(); commit = 1'b1; tick(4'h1);
        pix(1'b1, 11'd7, 10'd7, 8'h00, 8'h04); tick(4'h9);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        q.delete();
        exp_fc = '0;
        check("mid_rst_pending", {31'd0, pend}, 32'h0);
        check("mid_rst_valid", {31'd0, pvo}, 32'h0);
        check("mid_rst_color", {28'd0, color}, 32'h1);
        check("mid_rst_fc", {16'd0, fc}, 32'h0);
        fe(8'h00, 8'hFF); tick(4'h1);
        check("post_rst_pending", {31'd0, pend}, 32'h0);
        for (int i = 0; i < 3; i++) begin pix(1'b1, 11'(i), 10'd1, 8'h00, 8'hFF); tick(4'h1); end
        idle();
        repeat (L) tick(4'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
